// File: rtl/audio_nios_sysid_arbiter_pkg.sv
// Shared definitions for the two-master system-ID read arbiter:
// FSM state encodings and master index constants.
package audio_nios_sysid_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage

// File: rtl/audio_nios_sysid_arbiter_if.sv
// Avalon-MM read-only master port bundle. The master modport is the
// requesting side (Qsys interconnect); the slave modport is the
// arbiter side that accepts commands and returns read data.
interface audio_nios_sysid_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 1
);
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    modport master (
        output address,
        output read,
        input  waitrequest,
        input  readdata,
        input  readdatavalid
    );

    modport slave (
        input  address,
        input  read,
        output waitrequest,
        output readdata,
        output readdatavalid
    );
endinterface

// File: rtl/audio_nios_sysid_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick. A lone requester always wins;
// on a tie the master that was not granted last is chosen.
module audio_nios_rr_arb2
    import audio_nios_sysid_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant,
    output logic       grant_valid
);

    // Pick the winner from the current requests and the previous grant
    always_comb begin
        grant_valid = |req;
        grant       = M0;
        if (req == 2'b11) begin
            grant = ~last_grant;
        end else if (req[1]) begin
            grant = M1;
        end
    end

endmodule

// File: rtl/audio_nios_sysid_arbiter.sv
// Two-master read arbiter in front of the combinational system-ID slave.
// One read is in flight at a time: IDLE accepts, ACCESS presents the
// latched address and captures the slave data, RESP returns it to the
// granted master as a one-cycle readdatavalid pulse.
module audio_nios_sysid_arbiter
    import audio_nios_sysid_arb_pkg::*;
#(
    parameter int   DATA_W     = 32,
    parameter int   ADDR_W     = 1,
    parameter logic RESET_LAST = 1'b1
) (
    input  logic                       clock,
    input  logic                       reset_n,
    audio_nios_sysid_arbiter_if.slave  m0,
    audio_nios_sysid_arbiter_if.slave  m1,
    output logic [ADDR_W-1:0]          s_address,
    input  logic [DATA_W-1:0]          s_readdata
);

    arb_state_e        state_q;
    arb_state_e        state_d;
    logic              grant_q;
    logic              last_grant_q;
    logic              grant;
    logic              grant_valid;
    logic              accept;
    logic [DATA_W-1:0] m0_data_q;
    logic [DATA_W-1:0] m1_data_q;

    audio_nios_rr_arb2 u_rr_arb2 (
        .req         ({m1.read, m0.read}),
        .last_grant  (last_grant_q),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    // A command is accepted only in IDLE, and never while reset is held
    assign accept = reset_n && (state_q == IDLE) && grant_valid;

    // Next-state logic and combinational handshake outputs
    always_comb begin
        state_d          = state_q;
        m0.waitrequest   = 1'b1;
        m1.waitrequest   = 1'b1;
        m0.readdatavalid = 1'b0;
        m1.readdatavalid = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d        = ACCESS;
                    m0.waitrequest = (grant != M0);
                    m1.waitrequest = (grant != M1);
                end
            end
            ACCESS: state_d = RESP;
            RESP: begin
                state_d          = IDLE;
                m0.readdatavalid = (grant_q == M0);
                m1.readdatavalid = (grant_q == M1);
            end
            default: state_d = IDLE;
        endcase
    end

    // Per-master response data holds its last value between reads
    assign m0.readdata = m0_data_q;
    assign m1.readdata = m1_data_q;

    // FSM state, grant bookkeeping and the registered slave address
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            grant_q      <= M0;
            last_grant_q <= RESET_LAST;
            s_address    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                grant_q      <= grant;
                last_grant_q <= grant;
                s_address    <= (grant == M1) ? m1.address : m0.address;
            end
        end
    end

    // Capture slave data into the granted master's response register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m0_data_q <= '0;
            m1_data_q <= '0;
        end else if (state_q == ACCESS) begin
            if (grant_q == M0) begin
                m0_data_q <= s_readdata;
            end else begin
                m1_data_q <= s_readdata;
            end
        end
    end

endmodule

// File: tb/tb_audio_nios_sysid_arbiter.sv
// Directed bench for the system-ID read arbiter. A behavioural sysid slave
// returns 0 for word 0 and 0x5756_257A for word 1.
module tb_audio_nios_sysid_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 1;
    localparam logic [31:0] SYSID = 32'h0000_0000;
    localparam logic [31:0] STAMP = 32'h5756_257A;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic [ADDR_W-1:0] s_address;
    logic [DATA_W-1:0] s_readdata;
    int                checks = 0;
    int                errors = 0;

    audio_nios_sysid_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_m0 ();
    audio_nios_sysid_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_m1 ();

    audio_nios_sysid_arbiter #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .RESET_LAST (1'b1)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .m0         (bus_m0),
        .m1         (bus_m1),
        .s_address  (s_address),
        .s_readdata (s_readdata)
    );

    assign s_readdata = (s_address == 1'b1) ? STAMP : SYSID;

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        bus_m0.address = '0;
        bus_m0.read    = 1'b1;
        bus_m1.address = '0;
        bus_m1.read    = 1'b1;

        // Reset held with both masters requesting
        #2;
        chk("rst_wr0", {31'd0, bus_m0.waitrequest}, 32'd1);
        chk("rst_wr1", {31'd0, bus_m1.waitrequest}, 32'd1);
        chk("rst_rdv0", {31'd0, bus_m0.readdatavalid}, 32'd0);
        chk("rst_rdv1", {31'd0, bus_m1.readdatavalid}, 32'd0);
        chk("rst_rd0", bus_m0.readdata, 32'd0);
        chk("rst_rd1", bus_m1.readdata, 32'd0);
        chk("rst_saddr", {31'd0, s_address}, 32'd0);
        bus_m0.read = 1'b0;
        bus_m1.read = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();

        // m0 reads word 1, m1 idle
        bus_m0.address = 1'b1;
        bus_m0.read    = 1'b1;
        #1;
        chk("t1_accept_wr0", {31'd0, bus_m0.waitrequest}, 32'd0);
        chk("t1_accept_wr1", {31'd0, bus_m1.waitrequest}, 32'd1);
        tick();
        bus_m0.read = 1'b0;
        #1;
        chk("t1_access_saddr", {31'd0, s_address}, 32'd1);
        chk("t1_access_rdv0", {31'd0, bus_m0.readdatavalid}, 32'd0);
        tick();
        chk("t1_resp_rdv0", {31'd0, bus_m0.readdatavalid}, 32'd1);
        chk("t1_resp_rd0", bus_m0.readdata, STAMP);
        chk("t1_resp_rdv1", {31'd0, bus_m1.readdatavalid}, 32'd0);
        tick();
        chk("t1_after_rdv0", {31'd0, bus_m0.readdatavalid}, 32'd0);
        chk("t1_after_hold", bus_m0.readdata, STAMP);

        // m1 reads word 0; m0 request during ACCESS is ignored then withdrawn
        bus_m1.address = 1'b0;
        bus_m1.read    = 1'b1;
        #1;
        chk("t2_accept_wr1", {31'd0, bus_m1.waitrequest}, 32'd0);
        tick();
        bus_m1.read = 1'b0;
        bus_m0.read = 1'b1;
        #1;
        chk("t2_access_wr0", {31'd0, bus_m0.waitrequest}, 32'd1);
        chk("t2_access_rdv0", {31'd0, bus_m0.readdatavalid}, 32'd0);
        bus_m0.read = 1'b0;
        tick();
        chk("t2_resp_rdv1", {31'd0, bus_m1.readdatavalid}, 32'd1);
        chk("t2_resp_rd1", bus_m1.readdata, SYSID);
        chk("t2_resp_rdv0", {31'd0, bus_m0.readdatavalid}, 32'd0);
        chk("t2_m0_hold", bus_m0.readdata, STAMP);
        tick();
        chk("t2_idle_rdv0", {31'd0, bus_m0.readdatavalid}, 32'd0);

        // Simultaneous requests straight out of reset alternate m0,m1,m0,m1
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        bus_m0.address = 1'b1;
        bus_m1.address = 1'b0;
        bus_m0.read    = 1'b1;
        bus_m1.read    = 1'b1;
        #1;
        chk("t3_a_wr0", {31'd0, bus_m0.waitrequest}, 32'd0);
        chk("t3_a_wr1", {31'd0, bus_m1.waitrequest}, 32'd1);
        tick();
        chk("t3_a_access_wr0", {31'd0, bus_m0.waitrequest}, 32'd1);
        chk("t3_a_access_wr1", {31'd0, bus_m1.waitrequest}, 32'd1);
        tick();
        chk("t3_a_rdv0", {31'd0, bus_m0.readdatavalid}, 32'd1);
        chk("t3_a_rd0", bus_m0.readdata, STAMP);
        chk("t3_a_rdv1", {31'd0, bus_m1.readdatavalid}, 32'd0);
        tick();
        chk("t3_b_wr0", {31'd0, bus_m0.waitrequest}, 32'd1);
        chk("t3_b_wr1", {31'd0, bus_m1.waitrequest}, 32'd0);
        tick();
        tick();
        chk("t3_b_rdv1", {31'd0, bus_m1.readdatavalid}, 32'd1);
        chk("t3_b_rdv0", {31'd0, bus_m0.readdatavalid}, 32'd0);
        chk("t3_b_rd1", bus_m1.readdata, SYSID);
        tick();
        chk("t3_c_wr0", {31'd0, bus_m0.waitrequest}, 32'd0);
        chk("t3_c_wr1", {31'd0, bus_m1.waitrequest}, 32'd1);
        tick();
        tick();
        chk("t3_c_rdv0", {31'd0, bus_m0.readdatavalid}, 32'd1);
        tick();
        chk("t3_d_wr1", {31'd0, bus_m1.waitrequest}, 32'd0);
        chk("t3_d_wr0", {31'd0, bus_m0.waitrequest}, 32'd1);
        bus_m0.read = 1'b0;
        bus_m1.read = 1'b0;
        #1;
        chk("t3_withdraw_wr1", {31'd0, bus_m1.waitrequest}, 32'd1);
        tick();

        // m1 reads word 1 then changes its address after acceptance
        bus_m1.address = 1'b1;
        bus_m1.read    = 1'b1;
        #1;
        chk("t4_accept_wr1", {31'd0, bus_m1.waitrequest}, 32'd0);
        tick();
        bus_m1.address = 1'b0;
        bus_m1.read    = 1'b0;
        #1;
        chk("t4_access_saddr", {31'd0, s_address}, 32'd1);
        tick();
        chk("t4_resp_rdv1", {31'd0, bus_m1.readdatavalid}, 32'd1);
        chk("t4_resp_rd1", bus_m1.readdata, STAMP);
        tick();

        // Reset pulsed during ACCESS drops the in-flight read
        bus_m0.address = 1'b1;
        bus_m0.read    = 1'b1;
        #1;
        chk("t5_accept_wr0", {31'd0, bus_m0.waitrequest}, 32'd0);
        tick();
        bus_m1.read = 1'b1;
        reset_n     = 1'b0;
        #1;
        chk("t5_rst_wr0", {31'd0, bus_m0.waitrequest}, 32'd1);
        chk("t5_rst_wr1", {31'd0, bus_m1.waitrequest}, 32'd1);
        chk("t5_rst_rd0", bus_m0.readdata, 32'd0);
        chk("t5_rst_rd1", bus_m1.readdata, 32'd0);
        chk("t5_rst_saddr", {31'd0, s_address}, 32'd0);
        tick();
        bus_m0.read = 1'b0;
        bus_m1.read = 1'b0;
        reset_n     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_no_rdv0", {31'd0, bus_m0.readdatavalid}, 32'd0);
            chk("t5_no_rdv1", {31'd0, bus_m1.readdatavalid}, 32'd0);
        end
        bus_m0.read = 1'b1;
        #1;
        chk("t5_reissue_wr0", {31'd0, bus_m0.waitrequest}, 32'd0);
        tick();
        bus_m0.read = 1'b0;
        tick();
        chk("t5_reissue_rdv0", {31'd0, bus_m0.readdatavalid}, 32'd1);
        chk("t5_reissue_rd0", bus_m0.readdata, STAMP);
        tick();

        // m0 back-to-back: accepts every third cycle, one pulse per accept
        bus_m0.address = 1'b1;
        bus_m0.read    = 1'b1;
        for (int i = 0; i < 9; i++) begin
            #1;
            chk("t6_wr0", {31'd0, bus_m0.waitrequest}, (i % 3 == 0) ? 32'd0 : 32'd1);
            chk("t6_rdv0", {31'd0, bus_m0.readdatavalid}, (i % 3 == 2) ? 32'd1 : 32'd0);
            tick();
        end
        bus_m0.read = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
